// File: rtl/time_pkg.sv
// Shared display constants: 7-segment glyphs and scan digit order.
package time_pkg;

  localparam logic [6:0] SEG_E = 7'h79;

  // Glyphs indexed by digit value, active-high {g,f,e,d,c,b,a}
  localparam logic [9:0][6:0] SEG_TAB = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic [1:0] {
    DIG_SEC_U = 2'd0,
    DIG_SEC_T = 2'd1,
    DIG_MIN_U = 2'd2,
    DIG_MIN_T = 2'd3
  } dig_e;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-high 7-segment decoder; 'E' above 9.
module bcd_to_7seg
  import time_pkg::*;
(
  input  logic [3:0] val,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_E;
    if (val <= 4'd9) seg = SEG_TAB[val];
  end

endmodule

// File: rtl/time_display_scan.sv
// Frame-latched 4-digit multiplexed 7-segment scanner with guard time,
// leading-zero blanking and blinking colon.
module time_display_scan
  import time_pkg::*;
#(
  parameter int SLOT_CYCLES    = 12500,
  parameter int GUARD_CYCLES   = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int BLANK_LEAD     = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic [3:0] sec_u,
  input  logic [2:0] sec_t,
  input  logic [3:0] min_u,
  input  logic [2:0] min_t,
  input  logic       blink,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] GRD  = CW'(GUARD_CYCLES);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

  logic [CW-1:0] cnt;
  dig_e          idx;
  logic          pend;
  logic [3:0]    sh_su;
  logic [2:0]    sh_st;
  logic [3:0]    sh_mu;
  logic [2:0]    sh_mt;
  logic          sh_bl;

  logic [3:0] dval;
  logic       tens;
  logic [6:0] raw;
  logic [6:0] glyph;
  logic [3:0] an_act;
  logic       dp_act;
  logic       blank;
  logic       load;

  always_comb begin
    dval = sh_su;
    tens = 1'b0;
    unique case (1'b1)
      idx == DIG_SEC_U: dval = sh_su;
      idx == DIG_SEC_T: begin
        dval = {1'b0, sh_st};
        tens = 1'b1;
      end
      idx == DIG_MIN_U: dval = sh_mu;
      idx == DIG_MIN_T: begin
        dval = {1'b0, sh_mt};
        tens = 1'b1;
      end
    endcase
  end

  bcd_to_7seg u_dec (
    .val (dval),
    .seg (raw)
  );

  // Tens digits come from mod-6 counters, so 6 and 7 are errors too
  always_comb begin
    glyph = raw;
    if (tens && dval > 4'd5) glyph = SEG_E;
  end

  always_comb begin
    blank  = (BLANK_LEAD != 0) && idx == DIG_MIN_T
          && sh_mt == 3'd0;
    an_act = 4'b0000;
    if (en && cnt >= GRD && !blank)
      an_act = 4'b0001 << idx;
    dp_act = (idx == DIG_MIN_U) && sh_bl;
    load   = pend || (cnt == LAST && idx == DIG_MIN_T);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt   <= '0;
      idx   <= DIG_SEC_U;
      pend  <= 1'b1;
      sh_su <= '0;
      sh_st <= '0;
      sh_mu <= '0;
      sh_mt <= '0;
      sh_bl <= 1'b0;
      an    <= {4{AN_INV}};
      seg   <= {7{SEG_INV}};
      dp    <= SEG_INV;
    end else begin
      if (cnt == LAST) begin
        cnt <= '0;
        idx <= dig_e'(idx + 2'd1);
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (load) begin
        sh_su <= sec_u;
        sh_st <= sec_t;
        sh_mu <= min_u;
        sh_mt <= min_t;
        sh_bl <= blink;
      end
      pend <= 1'b0;
      an   <= an_act ^ {4{AN_INV}};
      seg  <= glyph ^ {7{SEG_INV}};
      dp   <= dp_act ^ SEG_INV;
    end
  end

endmodule

// File: tb/tb_time_display_scan.sv
// Self-checking bench: directed frame table, corner sequences, random vs model.
module tb_time_display_scan;

  localparam int S = 8;
  localparam int G = 2;

  localparam logic [6:0] TAB [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
  localparam logic [11:0] IDLE = {4'hF, 7'h7F, 1'b1};

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       en = 1'b0;
  logic       blink = 1'b0;
  logic [3:0] sec_u = '0;
  logic [2:0] sec_t = '0;
  logic [3:0] min_u = '0;
  logic [2:0] min_t = '0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  always #5 clk = ~clk;

  time_display_scan #(
    .SLOT_CYCLES    (S),
    .GUARD_CYCLES   (G),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1),
    .BLANK_LEAD     (1)
  ) dut (
    .clk   (clk),
    .clr   (clr),
    .en    (en),
    .sec_u (sec_u),
    .sec_t (sec_t),
    .min_u (min_u),
    .min_t (min_t),
    .blink (blink),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  typedef struct packed {
    logic [3:0]      su;
    logic [2:0]      st;
    logic [3:0]      mu;
    logic [2:0]      mt;
    logic            bl;
    logic            en;
    logic [3:0][3:0] an;
    logic [3:0][6:0] seg;
    logic [3:0]      dp;
  } vec_t;

  vec_t vecs [4];

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: time since reset release, frame-latched digits
  int          t;
  bit          pend;
  int          m_su, m_st, m_mu, m_mt;
  bit          m_bl;
  int          lcnt, lidx;
  logic [11:0] mexp;

  function automatic logic [6:0] glyph(int v, int lim);
    return (v < lim) ? TAB[v] : 7'h79;
  endfunction

  task automatic check(string nm, logic [11:0] act, logic [11:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d: got an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b",
               nm, t, act[11:8], act[7:1], act[0],
               exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  task automatic step();
    int v, lim;
    logic [3:0] oh;
    logic [3:0] a;
    @(posedge clk);
    if (clr) begin
      t = 0; pend = 1;
      m_su = 0; m_st = 0; m_mu = 0; m_mt = 0; m_bl = 0;
      lcnt = -1; lidx = -1;
      mexp = IDLE;
    end else begin
      lcnt = t % S;
      lidx = (t / S) % 4;
      case (lidx)
        0: begin v = m_su; lim = 10; end
        1: begin v = m_st; lim = 6; end
        2: begin v = m_mu; lim = 10; end
        default: begin v = m_mt; lim = 6; end
      endcase
      oh = 4'b0001 << lidx;
      a = (!en || lcnt < G || (lidx == 3 && m_mt == 0)) ? 4'hF : ~oh;
      mexp = {a, ~glyph(v, lim), !(lidx == 2 && m_bl)};
      if (pend || (t % (4 * S)) == 4 * S - 1) begin
        m_su = sec_u; m_st = sec_t; m_mu = min_u;
        m_mt = min_t; m_bl = blink;
      end
      pend = 0;
      t++;
    end
    #1;
    check("model", {an, seg, dp}, mexp);
  endtask

  initial begin
    bit found;
    vecs[0] = '{4'd7, 3'd4, 4'd2, 3'd1, 1'b1, 1'b1,
                {4'h7, 4'hB, 4'hD, 4'hE},
                {7'h79, 7'h24, 7'h19, 7'h78}, 4'b1011};
    vecs[1] = '{4'd8, 3'd5, 4'd9, 3'd0, 1'b0, 1'b1,
                {4'hF, 4'hB, 4'hD, 4'hE},
                {7'h40, 7'h10, 7'h12, 7'h00}, 4'b1111};
    vecs[2] = '{4'd0, 3'd6, 4'd3, 3'd6, 1'b1, 1'b1,
                {4'h7, 4'hB, 4'hD, 4'hE},
                {7'h06, 7'h30, 7'h06, 7'h40}, 4'b1011};
    vecs[3] = '{4'd15, 3'd7, 4'd10, 3'd5, 1'b1, 1'b0,
                {4'hF, 4'hF, 4'hF, 4'hF},
                {7'h12, 7'h06, 7'h06, 7'h06}, 4'b1011};

    foreach (vecs[i]) begin
      clr = 1;
      sec_u = vecs[i].su; sec_t = vecs[i].st;
      min_u = vecs[i].mu; min_t = vecs[i].mt;
      blink = vecs[i].bl; en = vecs[i].en;
      repeat (3) begin
        step();
        check("reset", {an, seg, dp}, IDLE);
      end
      clr = 0;
      for (int k = 0; k < 4 * S; k++) begin
        step();
        if (lcnt < G)
          check("guard", {an, 8'h00}, {4'hF, 8'h00});
        if (lcnt == G)
          check("frame", {an, seg, dp},
                {vecs[i].an[lidx], vecs[i].seg[lidx], vecs[i].dp[lidx]});
      end
    end

    // Mid-frame input change must wait for the frame boundary
    clr = 1;
    sec_u = 4'd7; sec_t = 3'd4; min_u = 4'd2; min_t = 3'd1;
    blink = 1; en = 1;
    repeat (2) step();
    clr = 0;
    for (int k = 0; k < 8 * S; k++) begin
      step();
      if (k == S + 3) begin
        sec_u = 4'd8;
        min_t = 3'd3;
      end
      if (k == 3 * S + G)
        check("tear_old", {an, seg, dp}, {4'h7, 7'h79, 1'b1});
      if (k == 4 * S + G)
        check("tear_su", {an, seg, dp}, {4'hE, 7'h00, 1'b1});
      if (k == 7 * S + G)
        check("tear_mt", {an, seg, dp}, {4'h7, 7'h30, 1'b1});
    end

    // Reset at counter 5 of slot 2, then fresh load at slot 0
    found = 0;
    for (int k = 0; k < 8 * S && !found; k++) begin
      step();
      if (lidx == 2 && lcnt == 5) found = 1;
    end
    if (!found) check("seek_slot2", 12'h000, 12'hFFF);
    clr = 1;
    step();
    check("midclr", {an, seg, dp}, IDLE);
    clr = 0;
    sec_u = 4'd3;
    found = 0;
    for (int k = 0; k < 2 * S && !found; k++) begin
      step();
      if (lidx == 0 && lcnt == G) begin
        found = 1;
        check("restart", {an, seg, dp}, {4'hE, 7'h30, 1'b1});
      end
    end
    if (!found) check("restart_seek", 12'h000, 12'hFFF);

    // Randomized run, every cycle compared against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) sec_u = 4'($urandom);
      if ($urandom_range(0, 7) == 0) sec_t = 3'($urandom);
      if ($urandom_range(0, 7) == 0) min_u = 4'($urandom);
      if ($urandom_range(0, 15) == 0) min_t = 3'($urandom);
      if ($urandom_range(0, 15) == 0) blink = ~blink;
      if ($urandom_range(0, 15) == 0) en = ~en;
      clr = ($urandom_range(0, 399) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
